// File: rtl/xor_descrambler.sv
// Self-synchronizing x^58 + x^39 + 1 descrambler, 32 bits per cycle,
// with a valid/ready input, a registered output stage and a word counter.
module xor_descrambler #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [31:0]      out_data,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             seed_load,
    input  logic [57:0]      seed,
    input  logic             bypass,
    output logic [CNT_W-1:0] word_count
);

    logic [57:0] hist;
    logic [31:0] descr;
    logic [31:0] d_rev;
    logic        accept;
    logic        out_hs;

    assign in_ready = !seed_load && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign out_hs   = out_valid && out_ready;

    // Both taps of every bit come from history, so no ripple across the word.
    always_comb begin
        descr = '0;
        d_rev = '0;
        for (int i = 0; i < 32; i++) begin
            descr[i] = in_data[i] ^ hist[38-i] ^ hist[57-i];
            d_rev[i] = in_data[31-i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist <= '0;
        end else if (seed_load) begin
            hist <= seed;
        end else if (accept) begin
            hist <= {hist[25:0], d_rev};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= bypass ? in_data : descr;
        end else if (out_hs) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_count <= '0;
        end else if (out_hs) begin
            word_count <= word_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_xor_descrambler.sv
// Bench for xor_descrambler: bit-serial stream model of the scrambler and
// descrambler, randomized traffic and stalls, known vectors, counter wrap.
module tb_xor_descrambler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        seed_load = 1'b0;
    logic [57:0] seed = '0;
    logic        bypass = 1'b0;

    logic        in_ready, out_valid;
    logic [31:0] out_data;
    logic [31:0] word_count;
    logic        in_ready4, out_valid4;
    logic [31:0] out_data4;
    logic [3:0]  word_count4;

    int n_cmp = 0;
    int n_fail = 0;
    int exp_cnt = 0;

    bit          st[$];
    bit          sst[$];
    logic [31:0] exp_q[$];

    logic        obs_acc, obs_hs, obs_rdy;
    logic [31:0] obs_data;

    xor_descrambler dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .seed_load(seed_load), .seed(seed), .bypass(bypass),
        .word_count(word_count)
    );

    xor_descrambler #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready4),
        .out_data(out_data4), .out_valid(out_valid4), .out_ready(out_ready),
        .seed_load(seed_load), .seed(seed), .bypass(bypass),
        .word_count(word_count4)
    );

    always #5 clk = ~clk;

    function automatic logic [57:0] rand58();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[57:0];
    endfunction

    // Stream history: index 57 is the most recent bit, index 0 is 58 bits back.
    task automatic model_reset();
        st.delete();
        for (int k = 0; k < 58; k++) st.push_back(1'b0);
    endtask

    task automatic model_seed(input logic [57:0] s);
        st.delete();
        for (int k = 57; k >= 0; k--) st.push_back(s[k]);
    endtask

    task automatic scr_seed(input logic [57:0] s);
        sst.delete();
        for (int k = 57; k >= 0; k--) sst.push_back(s[k]);
    endtask

    task automatic model_accept(input logic [31:0] d, input logic byp,
                                output logic [31:0] r);
        bit b;
        for (int i = 0; i < 32; i++) begin
            b = d[i] ^ st[19] ^ st[0];
            r[i] = byp ? d[i] : b;
            st.push_back(d[i]);
            void'(st.pop_front());
        end
    endtask

    task automatic scramble(input logic [31:0] p, output logic [31:0] s);
        bit b;
        for (int i = 0; i < 32; i++) begin
            b = p[i] ^ sst[19] ^ sst[0];
            s[i] = b;
            sst.push_back(b);
            void'(sst.pop_front());
        end
    endtask

    task automatic step(input logic v, input logic [31:0] d,
                        input logic ordy, input logic byp,
                        input logic sl, input logic [57:0] sd);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        bypass    = byp;
        seed_load = sl;
        seed      = sd;
        #1;
        obs_rdy  = in_ready;
        obs_acc  = v & in_ready;
        obs_hs   = out_valid & ordy;
        obs_data = out_data;
        if (obs_hs) exp_cnt++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        exp_cnt = 0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b expected 1", in_ready);
        end
        @(negedge clk);
        step(1, 32'hFFFF_FFFF, 1, 0, 0, '0);
        step(1, 32'h1234_5678, 0, 0, 0, '0);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_out: got v=%b d=%h expected v=0 d=00000000",
                     out_valid, out_data);
        end
        n_cmp++;
        if (word_count !== 32'd0 || word_count4 !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_cnt: got %0d/%0d expected 0",
                     word_count, word_count4);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        exp_cnt = 0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b expected 1", in_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_known();
        logic [31:0] r;
        step(1, 32'hFFFF_FFFF, 1, 0, 0, '0);
        model_accept(32'hFFFF_FFFF, 0, r);
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL known_ff: got v=%b d=%h expected v=1 d=ffffffff",
                     out_valid, out_data);
        end
        step(1, 32'h0, 1, 0, 0, '0);
        model_accept(32'h0, 0, r);
        n_cmp++;
        if (out_data !== 32'h03FF_FF80) begin
            n_fail++;
            $display("FAIL known_00: got %h expected 03ffff80", out_data);
        end
        do_reset();
        step(1, 32'hFFFF_FFFF, 1, 1, 0, '0);
        model_accept(32'hFFFF_FFFF, 1, r);
        n_cmp++;
        if (out_data !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL bypass_ff: got %h expected ffffffff", out_data);
        end
        step(1, 32'h0, 1, 1, 0, '0);
        model_accept(32'h0, 1, r);
        n_cmp++;
        if (out_data !== 32'h0) begin
            n_fail++;
            $display("FAIL bypass_00: got %h expected 00000000", out_data);
        end
        step(1, 32'h0, 1, 0, 0, '0);
        model_accept(32'h0, 0, r);
        n_cmp++;
        if (out_data !== r || out_data !== 32'h03FF_FF80) begin
            n_fail++;
            $display("FAIL bypass_hist: got %h expected %h", out_data, r);
        end
        step(0, 32'h0, 1, 0, 0, '0);
        n_cmp++;
        if (word_count !== 32'(exp_cnt) || exp_cnt != 3) begin
            n_fail++;
            $display("FAIL known_cnt: got %0d expected 3", word_count);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] a, r, d, e;
        logic        v, o, byp;
        int          accepted, cyc;
        a = $urandom();
        step(1, a, 1, 0, 0, '0);
        model_accept(a, 0, r);
        exp_q.push_back(r);
        repeat (5) begin
            step(1, $urandom(), 0, 0, 0, '0);
            n_cmp++;
            if (obs_rdy !== 1'b0 || obs_acc !== 1'b0 || obs_data !== r) begin
                n_fail++;
                $display("FAIL stall: got rdy=%b d=%h expected rdy=0 d=%h",
                         obs_rdy, obs_data, r);
            end
        end
        accepted = 0;
        cyc = 0;
        while (accepted < 1000 && cyc < 5000) begin
            v   = ($urandom_range(0, 3) != 0);
            d   = $urandom();
            o   = ($urandom_range(0, 9) < 7);
            byp = ($urandom_range(0, 9) == 0);
            step(v, d, o, byp, 0, '0);
            cyc++;
            if (obs_hs) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_extra: got %h expected no output",
                             obs_data);
                end else begin
                    e = exp_q.pop_front();
                    if (obs_data !== e) begin
                        n_fail++;
                        $display("FAIL rand_data: got %h expected %h",
                                 obs_data, e);
                    end
                end
            end
            if (obs_acc) begin
                model_accept(d, byp, r);
                exp_q.push_back(r);
                accepted++;
            end
        end
        n_cmp++;
        if (accepted < 1000) begin
            n_fail++;
            $display("FAIL rand_timeout: got %0d words expected 1000", accepted);
        end
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 10) begin
            step(0, '0, 1, 0, 0, '0);
            cyc++;
            if (obs_hs) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (obs_data !== e) begin
                    n_fail++;
                    $display("FAIL drain_data: got %h expected %h", obs_data, e);
                end
            end
        end
        n_cmp++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drain: got %0d left v=%b expected 0 left v=0",
                     exp_q.size(), out_valid);
        end
        n_cmp++;
        if (word_count !== 32'(exp_cnt)) begin
            n_fail++;
            $display("FAIL rand_cnt: got %0d expected %0d", word_count, exp_cnt);
        end
    endtask

    task automatic test_self_sync();
        logic [31:0] p, s, r, e;
        logic [57:0] sd;
        do_reset();
        scr_seed(rand58());
        for (int w = 1; w <= 10; w++) begin
            p = $urandom();
            scramble(p, s);
            step(1, s, 1, 0, 0, '0);
            model_accept(s, 0, r);
            e = (w >= 3) ? p : r;
            n_cmp++;
            if (obs_acc !== 1'b1 || out_data !== e) begin
                n_fail++;
                $display("FAIL sync_w%0d: got %h expected %h", w, out_data, e);
            end
        end
        sd = rand58();
        scr_seed(sd);
        step(1, $urandom(), 1, 0, 1, sd);
        model_seed(sd);
        n_cmp++;
        if (obs_rdy !== 1'b0 || obs_acc !== 1'b0) begin
            n_fail++;
            $display("FAIL seed_ready: got %b expected 0", obs_rdy);
        end
        for (int w = 1; w <= 10; w++) begin
            p = $urandom();
            scramble(p, s);
            step(1, s, 1, 0, 0, '0);
            model_accept(s, 0, r);
            n_cmp++;
            if (out_data !== p) begin
                n_fail++;
                $display("FAIL seeded_w%0d: got %h expected %h", w, out_data, p);
            end
        end
        step(0, '0, 1, 0, 0, '0);
        n_cmp++;
        if (word_count !== 32'(exp_cnt)) begin
            n_fail++;
            $display("FAIL sync_cnt: got %0d expected %0d", word_count, exp_cnt);
        end
    endtask

    task automatic test_count_wrap();
        int guard;
        do_reset();
        guard = 0;
        while (exp_cnt < 17 && guard < 40) begin
            step(1, $urandom(), 1, 0, 0, '0);
            guard++;
            if (exp_cnt >= 15) begin
                n_cmp++;
                if (word_count4 !== 4'(exp_cnt)) begin
                    n_fail++;
                    $display("FAIL wrap_%0d: got %0d expected %0d", exp_cnt,
                             word_count4, 4'(exp_cnt));
                end
            end
        end
        n_cmp++;
        if (exp_cnt != 17 || word_count !== 32'd17) begin
            n_fail++;
            $display("FAIL wrap_total: got %0d expected 17", word_count);
        end
    endtask

    task automatic test_mid_reset();
        logic [31:0] a, b;
        step(0, '0, 1, 0, 0, '0);
        a = $urandom();
        step(1, a, 1, 0, 0, '0);
        step(0, '0, 0, 0, 0, '0);
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_pending: got v=%b expected 1", out_valid);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_drop: got v=%b expected 0", out_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        exp_cnt = 0;
        step(0, '0, 1, 0, 0, '0);
        n_cmp++;
        if (obs_hs !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_ghost: got hs=%b expected 0", obs_hs);
        end
        b = $urandom();
        step(1, b, 1, 0, 0, '0);
        n_cmp++;
        if (out_data !== b || word_count !== 32'd0) begin
            n_fail++;
            $display("FAIL mid_first: got %h cnt=%0d expected %h cnt=0",
                     out_data, word_count, b);
        end
        step(0, '0, 1, 0, 0, '0);
        n_cmp++;
        if (word_count !== 32'd1) begin
            n_fail++;
            $display("FAIL mid_cnt: got %0d expected 1", word_count);
        end
    endtask

    initial begin
        test_reset();
        test_known();
        test_backpressure();
        test_self_sync();
        test_count_wrap();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
